// File: rtl/noc_bridge_axis_downsizer.sv
// Serialises one wide AXIS beat ({tuser, tdata}) into NumBeats narrow beats,
// LSB chunk first. Each narrow beat is tagged with its index and a last flag.
// A new wide beat can load on the handshake of the previous last beat, so
// there is no bubble between wide beats under continuous ready.
module noc_bridge_axis_downsizer #(
  parameter  int DataW    = 71,
  parameter  int UserW    = 12,
  parameter  int NarrowW  = 32,
  localparam int WideW    = DataW + UserW,
  localparam int NumBeatsRaw = (WideW + NarrowW - 1) / NarrowW,
  localparam int NumBeats = (NumBeatsRaw < 1) ? 1 : NumBeatsRaw,
  localparam int IdxW     = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wide_valid_i,
  output logic               wide_ready_o,
  input  logic [DataW-1:0]   wide_data_i,
  input  logic [UserW-1:0]   wide_user_i,
  output logic               narrow_valid_o,
  input  logic               narrow_ready_i,
  output logic [NarrowW-1:0] narrow_data_o,
  output logic               narrow_last_o,
  output logic [IdxW-1:0]    narrow_idx_o,
  output logic               busy_o
);

  localparam int PadW = NumBeats * NarrowW;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                           state_q;
  logic [IdxW-1:0]                  cnt_q;
  logic [WideW-1:0]                 hold_q;
  logic [NumBeats-1:0][NarrowW-1:0] chunks;
  logic                             last_beat;
  logic                             send;

  // Zero-pad the holding register up to a whole number of narrow beats so
  // the final beat carries zeros above WideW.
  if (PadW > WideW) begin : g_pad
    assign chunks = {{(PadW - WideW){1'b0}}, hold_q};
  end else begin : g_nopad
    assign chunks = hold_q;
  end

  assign send      = (state_q == SEND);
  assign last_beat = (cnt_q == IdxW'(NumBeats - 1));

  // Output decode; everything is gated by SEND so reset and IDLE present zeros.
  always_comb begin
    narrow_valid_o = send;
    narrow_data_o  = send ? chunks[cnt_q] : '0;
    narrow_last_o  = send && last_beat;
    narrow_idx_o   = cnt_q;
    busy_o         = send;
    // Wide side only accepts when the holding register frees up this cycle.
    wide_ready_o   = !send || (narrow_ready_i && last_beat);
  end

  // Control FSM: load on acceptance, step through beats on each handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wide_valid_i) begin
            hold_q  <= {wide_user_i, wide_data_i};
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (narrow_ready_i) begin
            if (last_beat) begin
              cnt_q <= '0;
              if (wide_valid_i) begin
                hold_q <= {wide_user_i, wide_data_i};
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + IdxW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef NOC_DS_NO_ASSERT
  // Narrow side must hold its beat steady while stalled.
  a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (narrow_valid_o && !narrow_ready_i) |=> (narrow_valid_o &&
      $stable(narrow_data_o) && $stable(narrow_last_o) && $stable(narrow_idx_o)));
  // A wide beat may only be taken in SEND on the last narrow beat.
  a_no_early: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(send && !last_beat && wide_valid_i && wide_ready_o));
  // Beat counter never leaves its range.
  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(cnt_q) < NumBeats);
`endif

endmodule

// File: tb/tb_noc_bridge_axis_downsizer.sv
// Bench for the AXIS downsizer: a 3-beat instance (NarrowW=32) and a 1-beat
// instance (NarrowW=128). Expected narrow beats come from slicing the wide
// value arithmetically; a scoreboard queue per instance is filled on every
// wide handshake and drained by a monitor on every narrow handshake.
module tb_noc_bridge_axis_downsizer;

  localparam int NB_A = 3;
  localparam int NB_B = 1;

  typedef struct {
    logic [127:0] d;
    logic         last;
    int           idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_wv, a_wr, a_nv, a_nr, a_nl, a_busy;
  logic [70:0] a_wd;
  logic [11:0] a_wu;
  logic [31:0] a_nd;
  logic [1:0]  a_ni;

  logic         b_wv, b_wr, b_nv, b_nr, b_nl, b_busy;
  logic [70:0]  b_wd;
  logic [11:0]  b_wu;
  logic [127:0] b_nd;
  logic [0:0]   b_ni;

  beat_t qa[$];
  beat_t qb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    rand_done = 0;

  noc_bridge_axis_downsizer #(.DataW(71), .UserW(12), .NarrowW(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .wide_valid_i(a_wv), .wide_ready_o(a_wr), .wide_data_i(a_wd), .wide_user_i(a_wu),
    .narrow_valid_o(a_nv), .narrow_ready_i(a_nr), .narrow_data_o(a_nd),
    .narrow_last_o(a_nl), .narrow_idx_o(a_ni), .busy_o(a_busy));

  noc_bridge_axis_downsizer #(.DataW(71), .UserW(12), .NarrowW(128)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .wide_valid_i(b_wv), .wide_ready_o(b_wr), .wide_data_i(b_wd), .wide_user_i(b_wu),
    .narrow_valid_o(b_nv), .narrow_ready_i(b_nr), .narrow_data_o(b_nd),
    .narrow_last_o(b_nl), .narrow_idx_o(b_ni), .busy_o(b_busy));

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference slice: chunk i of a wide value at narrow width nw.
  function automatic logic [127:0] chunk(logic [82:0] w, int nw, int i);
    logic [255:0] t;
    t = 256'(w) >> (i * nw);
    return t[127:0] & ((128'd1 << nw) - 128'd1);
  endfunction

  function automatic logic [70:0] rnd_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[70:0];
  endfunction

  function automatic logic [11:0] rnd_user();
    logic [31:0] r;
    r = $urandom;
    return r[11:0];
  endfunction

  // Wide-side handshake detectors: push the expected narrow beats.
  initial forever begin
    @(negedge clk); #1;
    if (rst_n && a_wv && a_wr)
      for (int i = 0; i < NB_A; i++)
        qa.push_back('{chunk({a_wu, a_wd}, 32, i), i == NB_A - 1, i});
    if (rst_n && b_wv && b_wr)
      for (int i = 0; i < NB_B; i++)
        qb.push_back('{chunk({b_wu, b_wd}, 128, i), i == NB_B - 1, i});
  end

  // Monitor A: beat order/content, stall stability, ready rule.
  initial begin
    logic stall = 1'b0;
    logic [35:0] prev = '0;
    beat_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("a_stall_stable", 128'({a_nv, a_nd, a_nl, a_ni}), 128'(prev));
        chk("a_wide_ready_rule", 128'(a_wr), 128'(a_nv ? (a_nr && a_nl) : 1'b1));
        chk("a_busy_eq_valid", 128'(a_busy), 128'(a_nv));
        if (a_nv && a_nr) begin
          if (qa.size() == 0) begin
            chk("a_unexpected_beat", 128'(1'b1), 128'(1'b0));
          end else begin
            e = qa.pop_front();
            chk("a_data", 128'(a_nd), e.d);
            chk("a_last", 128'(a_nl), 128'(e.last));
            chk("a_idx", 128'(a_ni), 128'(e.idx));
          end
        end
        stall = a_nv && !a_nr;
        prev  = {a_nv, a_nd, a_nl, a_ni};
      end
    end
  end

  // Monitor B: 1-beat instance.
  initial begin
    logic stall = 1'b0;
    logic [127:0] prev_d = '0;
    beat_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("b_stall_data", b_nd, prev_d);
          chk("b_stall_valid", 128'(b_nv), 128'(1'b1));
        end
        if (b_nv && b_nr) begin
          if (qb.size() == 0) begin
            chk("b_unexpected_beat", 128'(1'b1), 128'(1'b0));
          end else begin
            e = qb.pop_front();
            chk("b_data", b_nd, e.d);
            chk("b_last", 128'(b_nl), 128'(e.last));
            chk("b_idx", 128'(b_ni), 128'(e.idx));
          end
        end
        stall  = b_nv && !b_nr;
        prev_d = b_nd;
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic drain_a();
    int g = 0;
    a_nr = 1'b1;
    a_wv = 1'b0;
    @(negedge clk); #1;
    while ((a_busy || qa.size() != 0) && g < 60) begin
      @(negedge clk); #1;
      g++;
    end
    chk("a_drain_in_time", 128'(g < 60), 128'(1'b1));
  endtask

  initial begin
    logic [70:0] d;
    logic [11:0] u;
    int guard;
    int idle;
    rst_n = 1'b0;
    a_wv = 0; a_wd = '0; a_wu = '0; a_nr = 0;
    b_wv = 0; b_wd = '0; b_wu = '0; b_nr = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_valid", 128'(a_nv), 128'(1'b0));
    chk("rst_a_wready", 128'(a_wr), 128'(1'b1));
    chk("rst_a_last_idx_busy", 128'({a_nl, a_ni, a_busy}), 128'(4'b0));
    chk("rst_b_valid_wready", 128'({b_nv, b_wr}), 128'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single wide beat, constant expected chunks.
    @(negedge clk);
    a_nr = 1; a_wv = 1;
    a_wd = 71'h7F_0123_4567_89AB_CDEF; a_wu = 12'hABC;
    @(negedge clk); a_wv = 0; #1;
    chk("t1_b0", 128'({a_nv, a_nd, a_ni, a_nl}), 128'({1'b1, 32'h89ABCDEF, 2'd0, 1'b0}));
    @(negedge clk); #1;
    chk("t1_b1", 128'({a_nv, a_nd, a_ni, a_nl}), 128'({1'b1, 32'h01234567, 2'd1, 1'b0}));
    @(negedge clk); #1;
    chk("t1_b2", 128'({a_nv, a_nd, a_ni, a_nl}), 128'({1'b1, 32'h00055E7F, 2'd2, 1'b1}));
    @(negedge clk); #1;
    chk("t1_idle", 128'({a_nv, a_wr, a_busy}), 128'(3'b010));

    // 2: two back-to-back wide beats, six beats with no gap.
    @(negedge clk);
    a_wv = 1; a_wd = rnd_data(); a_wu = rnd_user();
    @(negedge clk);
    a_wd = rnd_data(); a_wu = rnd_user();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) a_wv = 0;
      #1;
      chk("t2_no_gap", 128'(a_nv), 128'(1'b1));
      chk("t2_wready_pulse", 128'(a_wr), 128'(k == 2 || k == 5));
    end
    @(negedge clk); #1;
    chk("t2_idle_after", 128'(a_nv), 128'(1'b0));

    // 4: stall on the last beat with the next wide beat waiting.
    @(negedge clk);
    a_wv = 1; a_wd = rnd_data(); a_wu = rnd_user();
    @(negedge clk);
    a_wd = rnd_data(); a_wu = rnd_user();
    @(negedge clk);
    @(negedge clk);
    a_nr = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("t4_stall_wready", 128'({a_wr, a_nv, a_nl}), 128'(3'b011));
    end
    @(negedge clk);
    a_nr = 1; #1;
    chk("t4_release_wready", 128'(a_wr), 128'(1'b1));
    @(negedge clk);
    a_wv = 0; #1;
    chk("t4_next_idx0", 128'({a_nv, a_ni}), 128'(3'b100));
    drain_a();

    // 5: reset during idx1.
    @(negedge clk);
    a_wv = 1; a_wd = rnd_data(); a_wu = rnd_user();
    @(negedge clk);
    a_wv = 0;
    @(negedge clk);
    a_nr = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outputs", 128'({a_nv, a_nl, a_ni, a_busy, a_nd}), 128'(0));
    chk("t5_rst_wready", 128'(a_wr), 128'(1'b1));
    qa.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_nr = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t5_no_stale", 128'(a_nv), 128'(1'b0));
    end
    @(negedge clk);
    a_wv = 1; a_wd = rnd_data(); a_wu = rnd_user();
    @(negedge clk);
    a_wv = 0; #1;
    chk("t5_fresh_idx0", 128'({a_nv, a_ni}), 128'(3'b100));
    drain_a();

    // 3: 1000 random wide beats with random downstream stalls.
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          idle = $urandom_range(0, 2);
          for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            a_wv = 0;
          end
          @(negedge clk);
          a_wv = 1; a_wd = rnd_data(); a_wu = rnd_user();
          #1;
          guard = 0;
          while (!a_wr && guard < 100) begin
            @(negedge clk); #1;
            guard++;
          end
          if (guard >= 100) chk("t3_accept_timeout", 128'(guard), 128'(0));
        end
        @(negedge clk);
        a_wv = 0;
        rand_done = 1;
      end
      begin
        int stall_left = 0;
        while (!rand_done) begin
          @(negedge clk);
          if (stall_left > 0) begin
            a_nr = 0;
            stall_left--;
          end else if ($urandom_range(0, 3) == 0) begin
            stall_left = $urandom_range(1, 5) - 1;
            a_nr = 0;
          end else begin
            a_nr = 1;
          end
        end
      end
    join
    drain_a();
    chk("t3_queue_empty", 128'(qa.size()), 128'(0));

    // 6: 1-beat instance, full throughput then random stalls.
    @(negedge clk);
    b_nr = 1;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      b_wv = 1; b_wd = rnd_data(); b_wu = rnd_user();
      #1;
      chk("t6_full_rate_wready", 128'(b_wr), 128'(1'b1));
      if (n > 0) begin
        chk("t6_valid_every_cycle", 128'({b_nv, b_nl, b_ni}), 128'(3'b110));
        chk("t6_upper_zero", 128'(b_nd[127:83]), 128'(0));
      end
    end
    @(negedge clk);
    b_wv = 0; #1;
    chk("t6_last_beat_valid", 128'(b_nv), 128'(1'b1));
    @(negedge clk); #1;
    chk("t6_idle", 128'(b_nv), 128'(1'b0));
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!b_wv || b_wr) begin
        b_wv = ($urandom_range(0, 2) != 0);
        b_wd = rnd_data(); b_wu = rnd_user();
      end
      b_nr = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    b_wv = 0; b_nr = 1;
    repeat (4) @(negedge clk);
    #3;
    chk("t6_queue_empty", 128'(qb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
